// File: rtl/hilo_issue_queue.sv
// In-order issue queue feeding the HI/LO functional unit.
// Buffers dispatched ops, captures operands from the result bus, and issues the oldest op once it is fully ready.
module hilo_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int ST_WD  = 32,
  parameter int TAG_WD = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [11:0]       enq_op,
  input  logic [ST_WD-1:0]  enq_status,
  input  logic              enq_s1_rdy,
  input  logic [TAG_WD-1:0] enq_s1_tag,
  input  logic [31:0]       enq_s1_val,
  input  logic              enq_s2_rdy,
  input  logic [TAG_WD-1:0] enq_s2_tag,
  input  logic [63:0]       enq_s2_val,
  input  logic              cdb_valid,
  input  logic [TAG_WD-1:0] cdb_tag,
  input  logic [31:0]       cdb_data,
  input  logic [31:0]       cdb_extra,
  input  logic              fu_done,
  output logic              iss_ready,
  output logic [11:0]       iss_op,
  output logic [ST_WD-1:0]  iss_status,
  output logic [31:0]       iss_rdata1,
  output logic [63:0]       iss_rdata2
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_s1_rdy;
  logic [DEPTH-1:0]  e_s2_rdy;
  logic [11:0]       e_op     [DEPTH];
  logic [ST_WD-1:0]  e_status [DEPTH];
  logic [TAG_WD-1:0] e_s1_tag [DEPTH];
  logic [TAG_WD-1:0] e_s2_tag [DEPTH];
  logic [31:0]       e_s1_val [DEPTH];
  logic [63:0]       e_s2_val [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          in_flight;

  logic do_enq;
  logic head_ready;
  logic enq_s1_byp;
  logic enq_s2_byp;

  assign enq_ready  = (count != FULL);
  assign do_enq     = enq_valid & enq_ready & ~flush;
  assign head_ready = e_valid[head] & e_s1_rdy[head] & e_s2_rdy[head];
  // fu_done in the same cycle frees the FU, so back-to-back issue is allowed
  assign iss_ready  = head_ready & (~in_flight | fu_done) & ~flush;
  assign enq_s1_byp = ~enq_s1_rdy & cdb_valid & (enq_s1_tag == cdb_tag);
  assign enq_s2_byp = ~enq_s2_rdy & cdb_valid & (enq_s2_tag == cdb_tag);

  always_comb begin
    iss_op     = '0;
    iss_status = '0;
    iss_rdata1 = '0;
    iss_rdata2 = '0;
    if (e_valid[head]) begin
      iss_op     = e_op[head];
      iss_status = e_status[head];
      iss_rdata1 = e_s1_val[head];
      iss_rdata2 = e_s2_val[head];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_valid   <= '0;
      e_s1_rdy  <= '0;
      e_s2_rdy  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      in_flight <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]     <= '0;
        e_status[i] <= '0;
        e_s1_tag[i] <= '0;
        e_s2_tag[i] <= '0;
        e_s1_val[i] <= '0;
        e_s2_val[i] <= '0;
      end
    end else begin
      // The FU always finishes its current op, so flush leaves in_flight alone
      if (iss_ready)
        in_flight <= 1'b1;
      else if (fu_done)
        in_flight <= 1'b0;

      if (flush) begin
        e_valid <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (e_valid[i] && cdb_valid && !e_s1_rdy[i] && (e_s1_tag[i] == cdb_tag)) begin
            e_s1_rdy[i] <= 1'b1;
            e_s1_val[i] <= cdb_data;
          end
          if (e_valid[i] && cdb_valid && !e_s2_rdy[i] && (e_s2_tag[i] == cdb_tag)) begin
            e_s2_rdy[i] <= 1'b1;
            e_s2_val[i] <= {cdb_extra, cdb_data};
          end
        end

        // The tail slot is never valid while enqueue is possible, so no wakeup collides with this write
        if (do_enq) begin
          e_valid[tail]  <= 1'b1;
          e_op[tail]     <= enq_op;
          e_status[tail] <= enq_status;
          e_s1_tag[tail] <= enq_s1_tag;
          e_s2_tag[tail] <= enq_s2_tag;
          e_s1_rdy[tail] <= enq_s1_rdy | enq_s1_byp;
          e_s2_rdy[tail] <= enq_s2_rdy | enq_s2_byp;
          e_s1_val[tail] <= enq_s1_byp ? cdb_data : enq_s1_val;
          e_s2_val[tail] <= enq_s2_byp ? {cdb_extra, cdb_data} : enq_s2_val;
          tail           <= tail + PW'(1);
        end

        if (iss_ready) begin
          e_valid[head] <= 1'b0;
          head          <= head + PW'(1);
        end

        case ({do_enq, iss_ready})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_issue_queue.sv
// Directed self-checking bench for hilo_issue_queue.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_hilo_issue_queue;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [11:0] enq_op;
  logic [31:0] enq_status;
  logic        enq_s1_rdy;
  logic [5:0]  enq_s1_tag;
  logic [31:0] enq_s1_val;
  logic        enq_s2_rdy;
  logic [5:0]  enq_s2_tag;
  logic [63:0] enq_s2_val;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [31:0] cdb_extra;
  logic        fu_done;
  logic        iss_ready;
  logic [11:0] iss_op;
  logic [31:0] iss_status;
  logic [31:0] iss_rdata1;
  logic [63:0] iss_rdata2;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] OP_MTLO = 12'h013;
  localparam logic [11:0] OP_MULT = 12'h018;
  localparam logic [11:0] OP_DIV  = 12'h01a;

  hilo_issue_queue #(.DEPTH(4), .ST_WD(32), .TAG_WD(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_op     (enq_op),
    .enq_status (enq_status),
    .enq_s1_rdy (enq_s1_rdy),
    .enq_s1_tag (enq_s1_tag),
    .enq_s1_val (enq_s1_val),
    .enq_s2_rdy (enq_s2_rdy),
    .enq_s2_tag (enq_s2_tag),
    .enq_s2_val (enq_s2_val),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .cdb_extra  (cdb_extra),
    .fu_done    (fu_done),
    .iss_ready  (iss_ready),
    .iss_op     (iss_op),
    .iss_status (iss_status),
    .iss_rdata1 (iss_rdata1),
    .iss_rdata2 (iss_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one dispatch offer; the caller decides when enq_valid drops
  task automatic applyStimulus(input logic [11:0] op, input logic [31:0] st,
                               input logic s1r, input logic [5:0] s1t, input logic [31:0] s1v,
                               input logic s2r, input logic [5:0] s2t, input logic [63:0] s2v);
    enq_valid  = 1'b1;
    enq_op     = op;
    enq_status = st;
    enq_s1_rdy = s1r;
    enq_s1_tag = s1t;
    enq_s1_val = s1v;
    enq_s2_rdy = s2r;
    enq_s2_tag = s2t;
    enq_s2_val = s2v;
  endtask

  task automatic finishFu();
    fu_done = 1'b1;
    tick();
    fu_done = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_op = '0; enq_status = '0;
    enq_s1_rdy = 1'b0; enq_s1_tag = '0; enq_s1_val = '0;
    enq_s2_rdy = 1'b0; enq_s2_tag = '0; enq_s2_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_extra = '0; fu_done = 1'b0;
    #2;
    checkOutput("rst_enq_ready", 64'(enq_ready), 64'd1);
    checkOutput("rst_iss_ready", 64'(iss_ready), 64'd0);
    checkOutput("rst_iss_op", 64'(iss_op), 64'd0);
    checkOutput("rst_iss_rdata2", iss_rdata2, 64'd0);
    #10 resetn = 1'b1;
    tick();

    // mtlo with ready source issues the cycle after enqueue
    applyStimulus(OP_MTLO, 32'hCAFE0001, 1'b1, 6'd0, 32'h12345678, 1'b1, 6'd0, 64'd0);
    #1 checkOutput("t1_empty_no_issue", 64'(iss_ready), 64'd0);
    tick();
    enq_valid = 1'b0;
    #1;
    checkOutput("t1_iss_ready", 64'(iss_ready), 64'd1);
    checkOutput("t1_rdata1", 64'(iss_rdata1), 64'h12345678);
    checkOutput("t1_op", 64'(iss_op), 64'(OP_MTLO));
    checkOutput("t1_status", 64'(iss_status), 64'hCAFE0001);
    tick();
    #1;
    checkOutput("t1_one_shot", 64'(iss_ready), 64'd0);
    checkOutput("t1_empty_payload", 64'(iss_rdata1), 64'd0);
    finishFu();

    // mult waits for tag 5 wakeup
    applyStimulus(OP_MULT, 32'h2, 1'b0, 6'd5, 32'hDEAD, 1'b1, 6'd0, 64'd0);
    tick();
    enq_valid = 1'b0;
    #1 checkOutput("t2_wait0", 64'(iss_ready), 64'd0);
    tick();
    #1 checkOutput("t2_wait1", 64'(iss_ready), 64'd0);
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h7; cdb_extra = 32'h0;
    #1 checkOutput("t2_no_same_cycle", 64'(iss_ready), 64'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    checkOutput("t2_iss_ready", 64'(iss_ready), 64'd1);
    checkOutput("t2_rdata1", 64'(iss_rdata1), 64'h7);
    tick();
    #1 checkOutput("t2_one_shot", 64'(iss_ready), 64'd0);
    tick();
    finishFu();

    // second op held behind an in-flight first op until fu_done
    applyStimulus(OP_MTLO, 32'h3, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h4, 1'b1, 6'd0, 32'hB2, 1'b1, 6'd0, 64'd0);
    #1;
    checkOutput("t3_first_issue", 64'(iss_ready), 64'd1);
    checkOutput("t3_first_rdata", 64'(iss_rdata1), 64'hA1);
    tick();
    enq_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("t3_hold%0d", k), 64'(iss_ready), 64'd0);
      checkOutput($sformatf("t3_head%0d", k), 64'(iss_rdata1), 64'hB2);
      tick();
    end
    fu_done = 1'b1;
    #1 checkOutput("t3_issue_on_done", 64'(iss_ready), 64'd1);
    tick();
    fu_done = 1'b0;
    #1 checkOutput("t3_after", 64'(iss_ready), 64'd0);
    finishFu();

    // fill with blocked head, check full, then wake and drain through the wrap
    applyStimulus(OP_MULT, 32'h10, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h11, 1'b1, 6'd0, 32'hC1, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h12, 1'b1, 6'd0, 32'hC2, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h13, 1'b1, 6'd0, 32'hC3, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h14, 1'b1, 6'd0, 32'hDD, 1'b1, 6'd0, 64'd0);
    #1;
    checkOutput("t4_full", 64'(enq_ready), 64'd0);
    checkOutput("t4_blocked", 64'(iss_ready), 64'd0);
    tick();
    #1 checkOutput("t4_still_full", 64'(enq_ready), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h33;
    tick();
    cdb_valid = 1'b0;
    #1;
    checkOutput("t4_head_issue", 64'(iss_ready), 64'd1);
    checkOutput("t4_head_rdata", 64'(iss_rdata1), 64'h33);
    checkOutput("t4_full_on_pop", 64'(enq_ready), 64'd0);
    tick();
    #1 checkOutput("t4_reopen", 64'(enq_ready), 64'd1);
    tick();
    enq_valid = 1'b0;
    #1;
    checkOutput("t4_next_head", 64'(iss_rdata1), 64'hC1);
    checkOutput("t4_wait_done", 64'(iss_ready), 64'd0);
    fu_done = 1'b1;
    #1 checkOutput("t4_drain_c1", 64'(iss_rdata1), 64'hC1);
    checkOutput("t4_drain_c1_rdy", 64'(iss_ready), 64'd1);
    tick();
    #1 checkOutput("t4_drain_c2", 64'(iss_rdata1), 64'hC2);
    checkOutput("t4_drain_c2_rdy", 64'(iss_ready), 64'd1);
    tick();
    #1 checkOutput("t4_drain_c3", 64'(iss_rdata1), 64'hC3);
    checkOutput("t4_drain_c3_rdy", 64'(iss_ready), 64'd1);
    tick();
    #1 checkOutput("t4_drain_wrap", 64'(iss_rdata1), 64'hDD);
    checkOutput("t4_drain_wrap_rdy", 64'(iss_ready), 64'd1);
    tick();
    #1 checkOutput("t4_empty", 64'(iss_ready), 64'd0);
    tick();
    fu_done = 1'b0;

    // s2 bypass from same-cycle broadcast
    applyStimulus(OP_MULT, 32'h20, 1'b1, 6'd0, 32'h1, 1'b0, 6'd9, 64'hFFFF);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hB; cdb_extra = 32'hA;
    tick();
    enq_valid = 1'b0; cdb_valid = 1'b0;
    #1;
    checkOutput("t5_bypass_issue", 64'(iss_ready), 64'd1);
    checkOutput("t5_rdata2", iss_rdata2, 64'h0000000A_0000000B);
    tick();
    finishFu();

    // flush with a div in flight
    applyStimulus(OP_DIV, 32'h30, 1'b1, 6'd0, 32'h64, 1'b1, 6'd0, 64'd0);
    tick();
    enq_valid = 1'b0;
    #1 checkOutput("t6_div_issue", 64'(iss_ready), 64'd1);
    tick();
    applyStimulus(OP_MTLO, 32'h31, 1'b1, 6'd0, 32'hE1, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h32, 1'b1, 6'd0, 32'hE2, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h33, 1'b1, 6'd0, 32'hE3, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h34, 1'b1, 6'd0, 32'hEE, 1'b1, 6'd0, 64'd0);
    flush = 1'b1;
    #1 checkOutput("t6_flush_no_issue", 64'(iss_ready), 64'd0);
    tick();
    flush = 1'b0;
    applyStimulus(OP_MTLO, 32'h35, 1'b1, 6'd0, 32'hF0, 1'b1, 6'd0, 64'd0);
    #1 checkOutput("t6_flushed_empty", 64'(iss_rdata1), 64'd0);
    tick();
    enq_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("t6_div_busy%0d", k), 64'(iss_ready), 64'd0);
      checkOutput($sformatf("t6_new_head%0d", k), 64'(iss_rdata1), 64'hF0);
      tick();
    end
    fu_done = 1'b1;
    #1 checkOutput("t6_issue_after_div", 64'(iss_ready), 64'd1);
    tick();
    fu_done = 1'b0;
    #1 checkOutput("t6_nothing_left", 64'(iss_rdata1), 64'd0);
    finishFu();

    // asynchronous reset in the middle of a div
    applyStimulus(OP_DIV, 32'h40, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 64'd0);
    tick();
    applyStimulus(OP_MTLO, 32'h41, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 64'd0);
    tick();
    enq_valid = 1'b0;
    #1 checkOutput("t7_pre_rst_head", 64'(iss_rdata1), 64'h77);
    #2 resetn = 1'b0;
    #1;
    checkOutput("t7_rst_enq_ready", 64'(enq_ready), 64'd1);
    checkOutput("t7_rst_iss_ready", 64'(iss_ready), 64'd0);
    checkOutput("t7_rst_rdata1", 64'(iss_rdata1), 64'd0);
    checkOutput("t7_rst_status", 64'(iss_status), 64'd0);
    #1 resetn = 1'b1;
    tick();
    applyStimulus(OP_MTLO, 32'h42, 1'b1, 6'd0, 32'h99, 1'b1, 6'd0, 64'd0);
    tick();
    enq_valid = 1'b0;
    #1;
    checkOutput("t7_post_rst_issue", 64'(iss_ready), 64'd1);
    checkOutput("t7_post_rst_rdata", 64'(iss_rdata1), 64'h99);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_issue_queue.md
# hilo_issue_queue

In-order issue queue that sits directly upstream of the HI/LO functional unit (mult/div/mfhi/mflo/mthi/mtlo). It buffers up to DEPTH HI/LO-class instructions from dispatch and captures missing operands from the result broadcast bus. It presents the oldest fully-ready instruction to the FU with a one-cycle `ready` strobe, and never issues while the FU still holds an unfinished operation.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- ST_WD, 32, width of the instruction-status word forwarded to the FU
- TAG_WD, 6, operand/result tag width
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard all queued entries
- enq_valid  in  1  dispatch offers an instruction
- enq_ready  out  1  queue can accept (count != DEPTH)
- enq_op  in  12  FU op code
- enq_status  in  ST_WD  instruction status word
- enq_s1_rdy / enq_s1_tag / enq_s1_val  in  1 / TAG_WD / 32  GPR source
- enq_s2_rdy / enq_s2_tag / enq_s2_val  in  1 / TAG_WD / 64  HI:LO source {hi,lo}
- cdb_valid / cdb_tag  in  1 / TAG_WD  result broadcast
- cdb_data / cdb_extra  in  32 / 32  broadcast lo/GPR value, hi value
- fu_done  in  1  FU completion (its cb_we)
- iss_ready  out  1  one-cycle load strobe to FU `ready`
- iss_op  out  12, iss_status  out  ST_WD, iss_rdata1  out  32, iss_rdata2  out  64  head entry payload

## Operation
- Circular buffer: head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus count of log2(DEPTH)+1 bits.
- Each entry holds valid, op, status, s1_rdy/tag/val, s2_rdy/tag/val.
- Enqueue when enq_valid & enq_ready & ~flush: write at tail, tail+1, count+1.
- Wakeup: for every valid entry with sX_rdy=0 and sX_tag==cdb_tag while cdb_valid: set sX_rdy=1. s1 captures cdb_data; s2 captures {cdb_extra, cdb_data}.
  - Entries already ready ignore matches.
  - Multiple matching entries all capture.
- Enqueue bypass: a source enqueued not-ready whose tag matches the same-cycle broadcast is written as ready with the broadcast value.
- In-flight flag: set on issue, cleared on fu_done. Issue is permitted when flag=0 or fu_done=1 in that cycle, so back-to-back issue is allowed.
- iss_ready = head valid & head s1_rdy & head s2_rdy & issue permitted & ~flush.
  - Combinational from state, with no dependence on enq or the current-cycle cdb.
  - On iss_ready: head+1, count−1, entry invalidated.
- iss_* carry the head payload while head is valid; otherwise all zero.
- Strictly in order: a not-ready head blocks younger ready entries.
- Flush: all entries invalid, head=tail=0, count=0; enqueue in that cycle is dropped.
  - The in-flight flag is NOT cleared by flush. It clears only via fu_done, because the FU finishes its current op regardless.
- Simultaneous enqueue and issue: count unchanged. enq_ready is derived from count only; no same-cycle pop credit.

## Timing
- Reset (async assert, sync-safe deassert): all entries invalid, pointers/count 0, in-flight 0.
  - Outputs at reset: enq_ready=1, iss_ready=0, iss_* zero.
- Enqueue at edge N: the entry is visible at head after edge N when the queue was empty, so iss_ready can assert in cycle N+1 if both sources were ready (or bypassed).
- Wakeup at edge N: the operand is ready from cycle N+1; earliest issue is N+1.
- iss_ready is high for exactly one cycle per instruction. The FU samples the payload on that edge.
- After issue, the next issue is no earlier than the cycle in which fu_done is high:
  - mthi/mtlo/mfhi/mflo: fu_done the cycle after issue.
  - mult: +2.
  - div: data-dependent.
- Full: enq_ready=0 while count==DEPTH; it reasserts the cycle after a pop.

## Test plan
- Reset, enqueue mtlo with s1 ready (val 0x12345678), FU idle → iss_ready high the next cycle with iss_rdata1=0x12345678; count returns to 0.
- Enqueue mult (s1 tag 5 not ready), then cdb_valid with tag 5 and data 0x7 → issue exactly one cycle after the broadcast with iss_rdata1=0x7; no earlier issue.
- Two ready ops, second enqueued while first in flight, fu_done held low for 5 cycles → second issues in the cycle fu_done=1, not before.
- Fill 4 entries with the head blocked on tag 3, enq_valid held → enq_ready=0. Wake tag 3 → head issues; enq_ready=1 on the following cycle; tail wraps to 0 correctly.
- Enqueue with s2 tag 9 not ready in the same cycle as cdb tag 9 with {extra,data}={0xA,0xB} → entry stored ready; iss_rdata2=0x0000000A_0000000B.
- Issue a div, then flush with 3 entries queued and immediately enqueue a ready op → flushed entries never issue; the new op issues only after fu_done for the div.
- Assert resetn low mid-div → all outputs return to reset values asynchronously.
